// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU (quotient to lo, remainder to hi)
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             cancel,
   output logic             busy,
   output logic             result_vld,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE, ZERO} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] acc, quo, dvs, acc_n, quo_n, a_mag, b_mag;
   logic [WIDTH:0] trial;
   logic neg_q, neg_r;
   assign busy = state != IDLE;
   assign result_vld = state == DONE || state == ZERO;
   // quo shifts the dividend magnitude out at the top and collects quotient bits at the bottom
   always_comb begin
      a_mag = signed_op && dividend[WIDTH-1] ? -dividend : dividend;
      b_mag = signed_op && divisor[WIDTH-1] ? -divisor : divisor;
      trial = {acc, quo[WIDTH-1]} - {1'b0, dvs};
      acc_n = trial[WIDTH] ? {acc[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], ~trial[WIDTH]};
   end
   always_ff @(posedge clk) begin
      if (rst_) begin
         state <= IDLE;
         cnt <= '0;
         quotient <= '0;
         remainder <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start && !cancel) begin
               acc <= '0;
               quo <= a_mag;
               dvs <= b_mag;
               cnt <= '0;
               neg_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               neg_r <= signed_op && dividend[WIDTH-1];
               if (divisor == '0) begin
                  state <= ZERO;
                  quotient <= '1;
                  remainder <= dividend;
                  div_zero <= 1'b1;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= acc_n;
               quo <= quo_n;
               cnt <= cnt + 1'b1;
               if (cancel) begin
                  state <= IDLE;
               end else if (cnt == CW'(WIDTH - 1)) begin
                  state <= DONE;
                  quotient <= neg_q ? -quo_n : quo_n;
                  remainder <= neg_r ? -acc_n : acc_n;
                  div_zero <= 1'b0;
               end
            end
            DONE: state <= IDLE;
            ZERO: state <= IDLE;
         endcase
      end
   end
endmodule
